// File: rtl/dataout_spi_tx_if.sv
// Bundle between the PIO word source and the SPI serialiser.
// master drives the word and requests; slave returns SPI pins and status.
interface dataout_spi_tx_if;
   logic [15:0] data_in;
   logic        auto_en;
   logic        force_send;
   logic        sclk;
   logic        sdo;
   logic        cs_n;
   logic        busy;
   logic [15:0] frame_count;

   modport master (
      output data_in, auto_en, force_send,
      input  sclk, sdo, cs_n, busy, frame_count
   );

   modport slave (
      input  data_in, auto_en, force_send,
      output sclk, sdo, cs_n, busy, frame_count
   );
endinterface

// File: rtl/dataout_spi_tx.sv
// Serialises each new 16-bit PIO word to an SPI DAC (mode 0, MSB first).
// Ports: clk, reset (async high), bus (slave: word in, SPI pins/status out).
module dataout_spi_tx #(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 2
) (
   input  logic clk,
   input  logic reset,
   dataout_spi_tx_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);

   state_t      state_q, state_d;
   logic [15:0] shadow_q, shadow_d;
   logic [15:0] last_sent_q, last_sent_d;
   logic        force_pend_q, force_pend_d;
   logic [7:0]  div_cnt_q, div_cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [3:0]  gap_cnt_q, gap_cnt_d;
   logic        sclk_q, sclk_d;
   logic        sdo_q, sdo_d;
   logic        cs_n_q, cs_n_d;
   logic        busy_q, busy_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic        start;
   logic [3:0]  bit_idx;

   always_comb begin
      state_d       = state_q;
      shadow_d      = shadow_q;
      last_sent_d   = last_sent_q;
      force_pend_d  = force_pend_q;
      div_cnt_d     = div_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      sclk_d        = sclk_q;
      sdo_d         = sdo_q;
      cs_n_d        = cs_n_q;
      busy_d        = busy_q;
      frame_count_d = frame_count_q;
      start         = 1'b0;
      // next bit to present after a falling SCLK
      bit_idx       = 4'd14 - bit_cnt_q;

      unique case (state_q)
         IDLE: begin
            start = (bus.auto_en && (bus.data_in != last_sent_q))
                    || bus.force_send || force_pend_q;
            if (start) begin
               shadow_d     = bus.data_in;
               last_sent_d  = bus.data_in;
               sdo_d        = bus.data_in[15];
               cs_n_d       = 1'b0;
               busy_d       = 1'b1;
               div_cnt_d    = '0;
               bit_cnt_d    = '0;
               force_pend_d = 1'b0;
               state_d      = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.force_send) force_pend_d = 1'b1;
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               sclk_d    = ~sclk_q;
               // data moves only on the falling edge
               if (sclk_q) begin
                  if (bit_cnt_q != 4'd15) begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                     sdo_d     = shadow_q[bit_idx];
                  end else begin
                     cs_n_d        = 1'b1;
                     sdo_d         = 1'b0;
                     frame_count_d = frame_count_q + 16'd1;
                     gap_cnt_d     = '0;
                     state_d       = GAP;
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end
         GAP: begin
            if (bus.force_send) force_pend_d = 1'b1;
            if (gap_cnt_q == GAP_LAST) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         shadow_q      <= '0;
         last_sent_q   <= '0;
         force_pend_q  <= 1'b0;
         div_cnt_q     <= '0;
         bit_cnt_q     <= '0;
         gap_cnt_q     <= '0;
         sclk_q        <= 1'b0;
         sdo_q         <= 1'b0;
         cs_n_q        <= 1'b1;
         busy_q        <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         last_sent_q   <= last_sent_d;
         force_pend_q  <= force_pend_d;
         div_cnt_q     <= div_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         sclk_q        <= sclk_d;
         sdo_q         <= sdo_d;
         cs_n_q        <= cs_n_d;
         busy_q        <= busy_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign bus.sclk        = sclk_q;
   assign bus.sdo         = sdo_q;
   assign bus.cs_n        = cs_n_q;
   assign bus.busy        = busy_q;
   assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_dataout_spi_tx.sv
// Bench for dataout_spi_tx: SPI frame monitor with expected-word queue,
// a table of idle-start vectors and hand sequences for multi-cycle cases.
module tb_dataout_spi_tx;

   localparam int CLK_DIV  = 2;
   localparam int CS_GAP   = 2;
   localparam int LOW_CYC  = 32 * CLK_DIV;
   localparam int BUSY_CYC = LOW_CYC + CS_GAP;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dataout_spi_tx_if bus ();

   dataout_spi_tx #(
      .CLK_DIV(CLK_DIV),
      .CS_GAP (CS_GAP)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic [15:0] data;
      logic        auto_en;
      logic        frc;
      logic        exp;
   } vec_t;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] exp_q[$];
   logic [15:0] fc_exp;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // frame monitor
   bit          in_frame = 0;
   logic [15:0] word = '0;
   int          nrise = 0;
   int          low_cnt = 0;
   int          busy_run = 0;
   logic        prev_sclk = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         in_frame  = 0;
         nrise     = 0;
         low_cnt   = 0;
         busy_run  = 0;
         prev_sclk = 1'b0;
      end else begin
         if (!bus.cs_n) begin
            if (!in_frame) begin
               in_frame = 1;
               nrise    = 0;
               low_cnt  = 0;
               word     = '0;
            end
            low_cnt++;
            if (bus.sclk && !prev_sclk) begin
               word = {word[14:0], bus.sdo};
               nrise++;
            end
         end else if (in_frame) begin
            in_frame = 0;
            chk("cs_n low cycles", low_cnt, LOW_CYC);
            chk("sclk rises", nrise, 16);
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected frame: got %h want none", word);
            end else begin
               chk("frame word", {16'h0, word}, {16'h0, exp_q.pop_front()});
            end
         end
         if (bus.busy) begin
            busy_run++;
         end else if (busy_run > 0) begin
            chk("busy high cycles", busy_run, BUSY_CYC);
            busy_run = 0;
         end
         prev_sclk = bus.sclk;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_lvl(input logic lvl, input int budget,
                           input string nm);
      int i = 0;
      while (bus.busy !== lvl && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk(nm, {31'h0, bus.busy}, {31'h0, lvl});
   endtask

   task automatic quiet(input int n, input string nm);
      logic seen = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (bus.busy) seen = 1'b1;
      end
      chk(nm, {31'h0, seen}, 32'h0);
   endtask

   task automatic pulse_force();
      bus.force_send = 1'b1;
      @(negedge clk);
      bus.force_send = 1'b0;
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{16'h8000, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{16'h1111, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{16'h1111, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{16'h1111, 1'b1, 1'b1, 1'b1};
      vecs[4] = '{16'h2222, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{16'hFFFF, 1'b0, 1'b1, 1'b1};

      reset          = 1'b1;
      bus.data_in    = '0;
      bus.auto_en    = 1'b0;
      bus.force_send = 1'b0;
      fc_exp         = '0;
      tick(3);
      chk("reset cs_n", {31'h0, bus.cs_n}, 32'h1);
      chk("reset sclk", {31'h0, bus.sclk}, 32'h0);
      chk("reset sdo", {31'h0, bus.sdo}, 32'h0);
      chk("reset busy", {31'h0, bus.busy}, 32'h0);
      chk("reset frame_count", {16'h0, bus.frame_count}, 32'h0);
      reset = 1'b0;

      // first frame, with two changes coalescing into one follow-up
      bus.auto_en = 1'b1;
      bus.data_in = 16'hA5C3;
      exp_q.push_back(16'hA5C3);
      wait_lvl(1'b1, 5, "t1 start");
      tick(10);
      bus.data_in = 16'h1234;
      tick(10);
      bus.data_in = 16'h0F0F;
      exp_q.push_back(16'h0F0F);
      wait_lvl(1'b0, 200, "t1 end");
      chk("t1 frame_count", {16'h0, bus.frame_count}, 32'd1);
      tick(1);
      chk("t2 follow-up next cycle", {31'h0, bus.busy}, 32'h1);
      wait_lvl(1'b0, 200, "t2 end");
      chk("t2 frame_count", {16'h0, bus.frame_count}, 32'd2);
      quiet(20, "t2 no third frame");

      // change and revert during a frame
      bus.data_in = 16'h3C3C;
      exp_q.push_back(16'h3C3C);
      wait_lvl(1'b1, 5, "t3 start");
      tick(10);
      bus.data_in = 16'h0001;
      tick(10);
      bus.data_in = 16'h3C3C;
      wait_lvl(1'b0, 200, "t3 end");
      quiet(20, "t3 no follow-up");
      chk("t3 frame_count", {16'h0, bus.frame_count}, 32'd3);

      // forced sends with auto disabled
      bus.auto_en = 1'b0;
      bus.data_in = 16'h8000;
      quiet(10, "t4 auto off no start");
      exp_q.push_back(16'h8000);
      pulse_force();
      chk("t4 force start", {31'h0, bus.busy}, 32'h1);
      tick(10);
      pulse_force();
      tick(10);
      pulse_force();
      exp_q.push_back(16'h8000);
      wait_lvl(1'b0, 200, "t4 end");
      tick(1);
      chk("t4 pending frame", {31'h0, bus.busy}, 32'h1);
      wait_lvl(1'b0, 200, "t4 pending end");
      quiet(20, "t4 pulses collapsed");
      exp_q.push_back(16'h8000);
      pulse_force();
      wait_lvl(1'b0, 200, "t4 idle force end");
      chk("t4 frame_count", {16'h0, bus.frame_count}, 32'd6);

      // idle start vectors
      fc_exp = 16'd6;
      for (int i = 0; i < 6; i++) begin
         bus.data_in = vecs[i].data;
         bus.auto_en = vecs[i].auto_en;
         if (vecs[i].exp) begin
            exp_q.push_back(vecs[i].data);
            fc_exp = fc_exp + 16'd1;
         end
         if (vecs[i].frc) pulse_force();
         else tick(1);
         chk($sformatf("vec%0d start", i), {31'h0, bus.busy},
             {31'h0, vecs[i].exp});
         if (vecs[i].exp) wait_lvl(1'b0, 200, $sformatf("vec%0d end", i));
         quiet(10, $sformatf("vec%0d no extra frame", i));
         chk($sformatf("vec%0d frame_count", i),
             {16'h0, bus.frame_count}, {16'h0, fc_exp});
      end

      // reset at the seventh SCLK rise of a forced 0xFFFF frame
      bus.auto_en = 1'b1;
      bus.data_in = 16'hFFFF;
      pulse_force();
      begin
         int   r = 0;
         int   g = 0;
         logic ps = bus.sclk;
         while (r < 7 && g < 200) begin
            @(negedge clk);
            g++;
            if (bus.sclk && !ps) r++;
            ps = bus.sclk;
         end
         chk("t5 reached rise 7", r, 7);
      end
      chk("t5 sdo before reset", {31'h0, bus.sdo}, 32'h1);
      reset = 1'b1;
      #1;
      chk("t5 abort cs_n", {31'h0, bus.cs_n}, 32'h1);
      chk("t5 abort sclk", {31'h0, bus.sclk}, 32'h0);
      chk("t5 abort sdo", {31'h0, bus.sdo}, 32'h0);
      chk("t5 abort busy", {31'h0, bus.busy}, 32'h0);
      chk("t5 abort frame_count", {16'h0, bus.frame_count}, 32'h0);
      tick(3);
      exp_q.push_back(16'hFFFF);
      reset = 1'b0;
      wait_lvl(1'b1, 5, "t5 resend start");
      wait_lvl(1'b0, 200, "t5 resend end");
      chk("t5 frame_count", {16'h0, bus.frame_count}, 32'd1);

      // frame_count wrap
      force dut.frame_count_q = 16'hFFFF;
      tick(1);
      release dut.frame_count_q;
      tick(1);
      chk("t6 preload", {16'h0, bus.frame_count}, 32'hFFFF);
      bus.data_in = 16'h5A5A;
      exp_q.push_back(16'h5A5A);
      wait_lvl(1'b1, 5, "t6 start");
      wait_lvl(1'b0, 200, "t6 end");
      chk("t6 wrap", {16'h0, bus.frame_count}, 32'h0);

      // zero word after reset sends nothing
      reset = 1'b1;
      bus.data_in = 16'h0000;
      tick(3);
      reset = 1'b0;
      quiet(30, "t6 zero after reset");
      chk("t6 frame_count after reset", {16'h0, bus.frame_count}, 32'h0);

      chk("scoreboard drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
